pipe_dest_tracker: RTL and testbench

- Producer side of the forwarding interface.
- Tracks destination/source register tags of in-flight instructions through the ID/EX, EX/MEM and MEM/WB stages.
- Drives the EX/MEM and MEM/WB write-back tags and the ID/EX source tags that the forwarding logic consumes.
- Also detects load-use hazards, generates the stall, injects bubbles on stall or branch flush, and keeps retire/stall counters for the performance test bench.

---
 rtl/pipe_dest_tracker.sv | 105 ++++++++++
 tb/tb_pipe_dest_tracker.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_dest_tracker.sv
// Register-tag tracker for the ID/EX, EX/MEM and MEM/WB stages.
// Produces the forwarding tags, the load-use stall, bubble injection and the retire/stall counters.
module pipe_dest_tracker #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid,
    input  logic              id_RegWrite,
    input  logic              id_MemRead,
    input  logic [REG_AW-1:0] id_RegRd,
    input  logic [REG_AW-1:0] id_RegRs,
    input  logic [REG_AW-1:0] id_RegRt,
    input  logic              id_UsesRt,
    input  logic              branch_flush,
    output logic              stall,
    output logic              flush_ifid,
    output logic [REG_AW-1:0] id_ex_RegRs,
    output logic [REG_AW-1:0] id_ex_RegRt,
    output logic              ex_mem_RegWrite,
    output logic [REG_AW-1:0] ex_mem_RegRd,
    output logic              mem_wb_RegWrite,
    output logic [REG_AW-1:0] mem_wb_RegRd,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    // A write to register 0 is architecturally a no-op, so it never enables write-back.
    function automatic logic wbEnable(input logic vld, input logic regWrite,
                                      input logic [REG_AW-1:0] rd);
        return vld & regWrite & (rd != '0);
    endfunction

    logic              vld_p0, regWrite_p0, memRead_p0;
    logic [REG_AW-1:0] rd_p0, rs_p0, rt_p0;
    logic              vld_p1, regWrite_p1;
    logic [REG_AW-1:0] rd_p1;
    logic              vld_p2, regWrite_p2;
    logic [REG_AW-1:0] rd_p2;
    logic [CNT_W-1:0]  retireCnt, stallCnt;
    logic              loadUse;

    assign loadUse = id_valid & vld_p0 & memRead_p0 & (rd_p0 != '0) &
                     ((rd_p0 == id_RegRs) | (id_UsesRt & (rd_p0 == id_RegRt)));
    // A flushed ID instruction is discarded anyway, so it must not also stall.
    assign stall      = loadUse & ~branch_flush;
    assign flush_ifid = branch_flush;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p0      <= 1'b0;
            regWrite_p0 <= 1'b0;
            memRead_p0  <= 1'b0;
            rd_p0       <= '0;
            rs_p0       <= '0;
            rt_p0       <= '0;
            vld_p1      <= 1'b0;
            regWrite_p1 <= 1'b0;
            rd_p1       <= '0;
            vld_p2      <= 1'b0;
            regWrite_p2 <= 1'b0;
            rd_p2       <= '0;
            retireCnt   <= '0;
            stallCnt    <= '0;
        end else begin
            // ID -> ID/EX
            if (branch_flush || stall) begin
                vld_p0      <= 1'b0;
                regWrite_p0 <= 1'b0;
                memRead_p0  <= 1'b0;
                rd_p0       <= '0;
                rs_p0       <= '0;
                rt_p0       <= '0;
            end else begin
                vld_p0      <= id_valid;
                regWrite_p0 <= id_valid & id_RegWrite;
                memRead_p0  <= id_valid & id_MemRead;
                rd_p0       <= id_RegRd;
                rs_p0       <= id_RegRs;
                rt_p0       <= id_RegRt;
            end
            // ID/EX -> EX/MEM
            vld_p1      <= vld_p0;
            regWrite_p1 <= regWrite_p0;
            rd_p1       <= rd_p0;
            // EX/MEM -> MEM/WB
            vld_p2      <= vld_p1;
            regWrite_p2 <= regWrite_p1;
            rd_p2       <= rd_p1;
            retireCnt   <= retireCnt + CNT_W'(vld_p2);
            stallCnt    <= stallCnt + CNT_W'(stall);
        end
    end

    assign id_ex_RegRs     = rs_p0;
    assign id_ex_RegRt     = rt_p0;
    assign ex_mem_RegWrite = wbEnable(vld_p1, regWrite_p1, rd_p1);
    assign ex_mem_RegRd    = rd_p1;
    assign mem_wb_RegWrite = wbEnable(vld_p2, regWrite_p2, rd_p2);
    assign mem_wb_RegRd    = rd_p2;
    assign retire_cnt      = retireCnt;
    assign stall_cnt       = stallCnt;

endmodule

// File: tb/tb_pipe_dest_tracker.sv
// Scoreboard bench for pipe_dest_tracker: a stage model predicts post-edge outputs,
// which are queued at drive time and compared once the DUT has clocked.
module tb_pipe_dest_tracker;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              id_valid, id_RegWrite, id_MemRead, id_UsesRt, branch_flush;
    logic [REG_AW-1:0] id_RegRd, id_RegRs, id_RegRt;
    logic              stall, flush_ifid, ex_mem_RegWrite, mem_wb_RegWrite;
    logic [REG_AW-1:0] id_ex_RegRs, id_ex_RegRt, ex_mem_RegRd, mem_wb_RegRd;
    logic [CNT_W-1:0]  retire_cnt, stall_cnt;

    pipe_dest_tracker #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_valid(id_valid), .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
        .id_RegRd(id_RegRd), .id_RegRs(id_RegRs), .id_RegRt(id_RegRt),
        .id_UsesRt(id_UsesRt), .branch_flush(branch_flush),
        .stall(stall), .flush_ifid(flush_ifid),
        .id_ex_RegRs(id_ex_RegRs), .id_ex_RegRt(id_ex_RegRt),
        .ex_mem_RegWrite(ex_mem_RegWrite), .ex_mem_RegRd(ex_mem_RegRd),
        .mem_wb_RegWrite(mem_wb_RegWrite), .mem_wb_RegRd(mem_wb_RegRd),
        .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic              vld, rw, mr;
        logic [REG_AW-1:0] rd, rs, rt;
    } stage_t;

    typedef struct packed {
        logic [REG_AW-1:0] idexRs, idexRt;
        logic              exmemWe;
        logic [REG_AW-1:0] exmemRd;
        logic              memwbWe;
        logic [REG_AW-1:0] memwbRd;
        logic [CNT_W-1:0]  retire, stallC;
    } exp_t;

    stage_t           mIdEx, mExMem, mMemWb;
    logic [CNT_W-1:0] mRetire, mStall;
    exp_t             sb[$];
    int               nChecks = 0;
    int               nErrors = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nChecks++;
        if (obs !== expv) begin
            nErrors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic wbExp(input stage_t s);
        return s.vld && s.rw && (s.rd != 0);
    endfunction

    // One clock: drive ID inputs, check the combinational outputs, predict, clock, compare.
    task automatic step(input string tag, input logic rst, input logic v, input logic rw,
                        input logic mr, input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs,
                        input logic [REG_AW-1:0] rt, input logic usesRt, input logic flush);
        logic   expStall;
        exp_t   e, got;
        @(negedge clk_i);
        rst_i = rst; id_valid = v; id_RegWrite = rw; id_MemRead = mr;
        id_RegRd = rd; id_RegRs = rs; id_RegRt = rt; id_UsesRt = usesRt; branch_flush = flush;
        #1;
        expStall = v && mIdEx.vld && mIdEx.mr && (mIdEx.rd != 0) &&
                   ((mIdEx.rd == rs) || (usesRt && (mIdEx.rd == rt))) && !flush;
        checkVal({tag, " flush_ifid"}, 32'(flush_ifid), 32'(flush));
        if (!rst) checkVal({tag, " stall"}, 32'(stall), 32'(expStall));
        if (rst) begin
            mIdEx = '0; mExMem = '0; mMemWb = '0; mRetire = '0; mStall = '0;
        end else begin
            mRetire = mRetire + CNT_W'(mMemWb.vld);
            mStall  = mStall + CNT_W'(expStall);
            mMemWb  = mExMem;
            mExMem  = mIdEx;
            if (flush || expStall) mIdEx = '0;
            else mIdEx = '{vld: v, rw: v & rw, mr: v & mr, rd: rd, rs: rs, rt: rt};
        end
        e.idexRs = mIdEx.rs;   e.idexRt = mIdEx.rt;
        e.exmemWe = wbExp(mExMem); e.exmemRd = mExMem.rd;
        e.memwbWe = wbExp(mMemWb); e.memwbRd = mMemWb.rd;
        e.retire = mRetire;    e.stallC = mStall;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        got = sb.pop_front();
        checkVal({tag, " id_ex_RegRs"}, 32'(id_ex_RegRs), 32'(got.idexRs));
        checkVal({tag, " id_ex_RegRt"}, 32'(id_ex_RegRt), 32'(got.idexRt));
        checkVal({tag, " ex_mem_RegWrite"}, 32'(ex_mem_RegWrite), 32'(got.exmemWe));
        checkVal({tag, " ex_mem_RegRd"}, 32'(ex_mem_RegRd), 32'(got.exmemRd));
        checkVal({tag, " mem_wb_RegWrite"}, 32'(mem_wb_RegWrite), 32'(got.memwbWe));
        checkVal({tag, " mem_wb_RegRd"}, 32'(mem_wb_RegRd), 32'(got.memwbRd));
        checkVal({tag, " retire_cnt"}, retire_cnt, got.retire);
        checkVal({tag, " stall_cnt"}, stall_cnt, got.stallC);
    endtask

    task automatic nop(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [CNT_W-1:0] stallBefore;
        mIdEx = '0; mExMem = '0; mMemWb = '0; mRetire = '0; mStall = '0;
        rst_i = 1'b1; id_valid = 1'b0; id_RegWrite = 1'b0; id_MemRead = 1'b0;
        id_RegRd = '0; id_RegRs = '0; id_RegRt = '0; id_UsesRt = 1'b0; branch_flush = 1'b0;

        // 1. Reset held with a valid ID instruction present
        step("rst0", 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0);
        step("rst1", 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0);
        checkVal("rst retire abs", retire_cnt, 32'd0);
        checkVal("rst stall abs", stall_cnt, 32'd0);
        checkVal("rst ex_mem_RegWrite abs", 32'(ex_mem_RegWrite), 32'd0);

        // 2. Latency of add $3
        step("add3", 1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0);
        nop("lat1");
        checkVal("lat ex_mem_RegRd abs", 32'(ex_mem_RegRd), 32'd3);
        checkVal("lat ex_mem_RegWrite abs", 32'(ex_mem_RegWrite), 32'd1);
        nop("lat2");
        checkVal("lat mem_wb_RegRd abs", 32'(mem_wb_RegRd), 32'd3);
        nop("lat3");
        checkVal("lat retire abs", retire_cnt, 32'd1);

        // 3. Load-use on rs
        step("lw5", 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
        step("use5a", 1'b0, 1'b1, 1'b1, 1'b0, 5'd6, 5'd5, 5'd1, 1'b1, 1'b0);
        checkVal("lu id_ex_RegRs abs", 32'(id_ex_RegRs), 32'd0);
        checkVal("lu ex_mem_RegRd abs", 32'(ex_mem_RegRd), 32'd5);
        checkVal("lu stall_cnt abs", stall_cnt, 32'd1);
        step("use5b", 1'b0, 1'b1, 1'b1, 1'b0, 5'd6, 5'd5, 5'd1, 1'b1, 1'b0);
        checkVal("lu2 id_ex_RegRs abs", 32'(id_ex_RegRs), 32'd5);
        checkVal("lu2 stall_cnt abs", stall_cnt, 32'd1);

        // 4. Rt gating
        step("lw7a", 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
        step("rt7off", 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd7, 1'b0, 1'b0);
        step("lw7b", 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
        step("rt7on", 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd7, 1'b1, 1'b0);
        step("rt7on2", 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd7, 1'b1, 1'b0);
        checkVal("rt stall_cnt abs", stall_cnt, 32'd2);

        // 5. Flush wins over load-use
        step("lw5f", 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
        stallBefore = mStall;
        step("flush", 1'b0, 1'b1, 1'b1, 1'b0, 5'd8, 5'd5, 5'd0, 1'b0, 1'b1);
        checkVal("flush id_ex_RegRs abs", 32'(id_ex_RegRs), 32'd0);
        checkVal("flush stall_cnt keep", stall_cnt, stallBefore);

        // 6. Register zero
        step("lw0", 1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step("rs0", 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        nop("z1");
        checkVal("z ex_mem_RegWrite abs", 32'(ex_mem_RegWrite), 32'd0);
        nop("z2");
        nop("z3");

        // Random traffic with a mid-run reset
        for (int i = 0; i < 300; i++) begin
            step("rnd", (i == 150), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0));
        end
        nop("end1");
        nop("end2");

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
